// File: rtl/freq_div_fsk_pkg.sv
// freq_div_pkg: shared constants for the mark/space FSK divider.
// Holds the symbol encoding and the terminal-count helper.
package freq_div_pkg;

   localparam logic SYM_MARK  = 1'b1;
   localparam logic SYM_SPACE = 1'b0;

   // Terminal count of a w-bit up-counter: 2^w-1.
   function automatic longint unsigned cmax(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/freq_div_fsk_if.sv
// freq_div_fsk_if: control/status bundle of the FSK divider.
// master drives init/en/sym/reloads; slave returns div_out/tick/sym_act.
interface freq_div_fsk_if #(
   parameter int WIDTH = 9
);

   logic             init;
   logic             en;
   logic             sym;
   logic [WIDTH-1:0] cnt_mark;
   logic [WIDTH-1:0] cnt_space;
   logic             div_out;
   logic             tick;
   logic             sym_act;

   modport master (
      output init, en, sym, cnt_mark, cnt_space,
      input  div_out, tick, sym_act
   );

   modport slave (
      input  init, en, sym, cnt_mark, cnt_space,
      output div_out, tick, sym_act
   );

endinterface

// File: rtl/freq_div_fsk_core.sv
// freq_div_core: WIDTH-bit up-counter with synchronous load and wrap flag.
// Ports: clk, rst, load_i, en_i, load_val_i in; cnt_o, wrap_o (cnt==CMAX) out.
module freq_div_core
   import freq_div_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             wrap_o
);

   localparam logic [WIDTH-1:0] CMAX = WIDTH'(cmax(WIDTH));

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign wrap_o = (cnt_q == CMAX);
   assign cnt_o  = cnt_q;

   // Load has priority; the counter stops at CMAX unless reloaded.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && !wrap_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/freq_div_fsk.sv
// freq_div_fsk: mark/space reload divider producing a square wave for FSK.
// Ports: clk, rst (sync, active high); bus = freq_div_fsk_if.slave
//   (init, en, sym, cnt_mark, cnt_space in; div_out, tick, sym_act out).
// Macro FREQ_DIV_SYNC_SWITCH_EN: symbol changes only take effect at wrap
// (phase continuous). Undefined: a symbol change reloads immediately.
module freq_div_fsk
   import freq_div_pkg::*;
#(
   parameter int   WIDTH    = 9,
   parameter logic INIT_SYM = SYM_SPACE
) (
   input  logic           clk,
   input  logic           rst,
   freq_div_fsk_if.slave  bus
);

   logic             div_q, div_d;
   logic             tick_q, tick_d;
   logic             sym_q, sym_d;
   logic             wrap;
   logic             load;
   logic             do_wrap;
   logic             switch_now;
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] cnt;

   // Every load path (init, wrap, immediate switch) uses the live sym.
   assign reload  = (bus.sym == SYM_MARK) ? bus.cnt_mark : bus.cnt_space;
   assign do_wrap = !bus.init && bus.en && wrap;

`ifdef FREQ_DIV_SYNC_SWITCH_EN
   assign switch_now = 1'b0;
`else
   assign switch_now = !bus.init && bus.en && !wrap && (bus.sym != sym_q);
`endif

   assign load = bus.init || do_wrap || switch_now;

   freq_div_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .en_i       (bus.en),
      .load_val_i (reload),
      .cnt_o      (cnt),
      .wrap_o     (wrap)
   );

   always_comb begin
      div_d  = div_q;
      tick_d = 1'b0;
      sym_d  = sym_q;
      if (bus.init) begin
         div_d = 1'b0;
         sym_d = bus.sym;
      end else if (do_wrap) begin
         div_d  = ~div_q;
         tick_d = 1'b1;
         sym_d  = bus.sym;
      end else if (switch_now) begin
         sym_d = bus.sym;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= 1'b0;
         tick_q <= 1'b0;
         sym_q  <= INIT_SYM;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
         sym_q  <= sym_d;
      end
   end

   assign bus.div_out = div_q;
   assign bus.tick    = tick_q;
   assign bus.sym_act = sym_q;

endmodule

// File: tb/tb_freq_div_fsk.sv
// tb_freq_div_fsk: directed checks of freq_div_fsk with WIDTH=9.
// Covers reset, mark/space periods, extremes, symbol switching, wrap corners.
module tb_freq_div_fsk;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   freq_div_fsk_if #(.WIDTH(9)) ifc ();

   freq_div_fsk #(
      .WIDTH    (9),
      .INIT_SYM (1'b0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Cycles until tick is seen (inclusive); -1 if limit expires.
   task automatic count_to_tick(input int lim, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!ifc.tick && n < lim);
      if (!ifc.tick) n = -1;
   endtask

   task automatic do_init(input logic s);
      ifc.sym  = s;
      ifc.init = 1'b1;
      cyc();
      ifc.init = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ifc.init = 1'b0;
      ifc.en = 1'b0;
      ifc.sym = 1'b1;
      ifc.cnt_mark = 9'd500;
      ifc.cnt_space = 9'd506;
      cyc();
      cyc();
      checks++;
      if (ifc.div_out !== 1'b0 || ifc.tick !== 1'b0 || ifc.sym_act !== 1'b0) begin
         fails++;
         $display("FAIL reset_vals: div=%b tick=%b sym=%b want 0 0 0",
                  ifc.div_out, ifc.tick, ifc.sym_act);
      end
      rst = 1'b0;
      repeat (3) cyc();
      checks++;
      if (ifc.div_out !== 1'b0 || ifc.tick !== 1'b0 || ifc.sym_act !== 1'b0) begin
         fails++;
         $display("FAIL idle_vals: div=%b tick=%b sym=%b want 0 0 0",
                  ifc.div_out, ifc.tick, ifc.sym_act);
      end
      checks++;
      if (dut.u_core.cnt_o !== 9'd0) begin
         fails++;
         $display("FAIL idle_cnt: got %0d want 0", dut.u_core.cnt_o);
      end
   endtask

   task automatic test_mark_period();
      int n;
      ifc.cnt_mark = 9'd500;
      do_init(1'b1);
      checks++;
      if (ifc.sym_act !== 1'b1 || ifc.div_out !== 1'b0 || dut.u_core.cnt_o !== 9'd500) begin
         fails++;
         $display("FAIL mark_init: sym=%b div=%b cnt=%0d want 1 0 500",
                  ifc.sym_act, ifc.div_out, dut.u_core.cnt_o);
      end
      ifc.en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         count_to_tick(40, n);
         checks++;
         if (n !== 12 || ifc.div_out !== ((k % 2) == 0)) begin
            fails++;
            $display("FAIL mark_half%0d: n=%0d div=%b want 12 %b",
                     k, n, ifc.div_out, (k % 2) == 0);
         end
      end
      cyc();
      checks++;
      if (ifc.tick !== 1'b0) begin
         fails++;
         $display("FAIL tick_pulse: got %b want 0", ifc.tick);
      end
   endtask

   task automatic test_extremes();
      int n;
      ifc.cnt_mark = 9'd511;
      do_init(1'b1);
      for (int k = 0; k < 2; k++) begin
         count_to_tick(4, n);
         checks++;
         if (n !== 1 || ifc.div_out !== (k == 0)) begin
            fails++;
            $display("FAIL fast_half%0d: n=%0d div=%b want 1 %b",
                     k, n, ifc.div_out, k == 0);
         end
      end
      ifc.cnt_space = 9'd0;
      do_init(1'b0);
      checks++;
      if (ifc.sym_act !== 1'b0 || dut.u_core.cnt_o !== 9'd0) begin
         fails++;
         $display("FAIL slow_init: sym=%b cnt=%0d want 0 0",
                  ifc.sym_act, dut.u_core.cnt_o);
      end
      count_to_tick(600, n);
      checks++;
      if (n !== 512 || ifc.div_out !== 1'b1) begin
         fails++;
         $display("FAIL slow_half: n=%0d div=%b want 512 1", n, ifc.div_out);
      end
   endtask

   task automatic test_switch();
      int n;
      ifc.cnt_mark = 9'd500;
      ifc.cnt_space = 9'd506;
      do_init(1'b1);
      repeat (4) cyc();
      ifc.sym = 1'b0;
      cyc();
`ifdef FREQ_DIV_SYNC_SWITCH_EN
      checks++;
      if (ifc.sym_act !== 1'b1 || ifc.tick !== 1'b0 || dut.u_core.cnt_o !== 9'd505) begin
         fails++;
         $display("FAIL sync_defer: sym=%b tick=%b cnt=%0d want 1 0 505",
                  ifc.sym_act, ifc.tick, dut.u_core.cnt_o);
      end
      count_to_tick(40, n);
      checks++;
      if (n !== 7 || ifc.sym_act !== 1'b0 || ifc.div_out !== 1'b1) begin
         fails++;
         $display("FAIL sync_first: n=%0d sym=%b div=%b want 7 0 1",
                  n, ifc.sym_act, ifc.div_out);
      end
`else
      checks++;
      if (ifc.sym_act !== 1'b0 || ifc.tick !== 1'b0 || ifc.div_out !== 1'b0 ||
          dut.u_core.cnt_o !== 9'd506) begin
         fails++;
         $display("FAIL imm_reload: sym=%b tick=%b div=%b cnt=%0d want 0 0 0 506",
                  ifc.sym_act, ifc.tick, ifc.div_out, dut.u_core.cnt_o);
      end
      count_to_tick(40, n);
      checks++;
      if (n !== 6 || ifc.sym_act !== 1'b0 || ifc.div_out !== 1'b1) begin
         fails++;
         $display("FAIL imm_first: n=%0d sym=%b div=%b want 6 0 1",
                  n, ifc.sym_act, ifc.div_out);
      end
`endif
      count_to_tick(40, n);
      checks++;
      if (n !== 6 || ifc.div_out !== 1'b0) begin
         fails++;
         $display("FAIL space_half: n=%0d div=%b want 6 0", n, ifc.div_out);
      end
   endtask

   task automatic test_wrap_edges();
      int n;
      ifc.cnt_mark = 9'd500;
      do_init(1'b1);
      count_to_tick(40, n);
      repeat (11) cyc();
      ifc.init = 1'b1;
      cyc();
      ifc.init = 1'b0;
      checks++;
      if (n !== 12 || ifc.div_out !== 1'b0 || ifc.tick !== 1'b0 ||
          dut.u_core.cnt_o !== 9'd500) begin
         fails++;
         $display("FAIL init_on_wrap: n=%0d div=%b tick=%b cnt=%0d want 12 0 0 500",
                  n, ifc.div_out, ifc.tick, dut.u_core.cnt_o);
      end
      repeat (3) cyc();
      ifc.en = 1'b0;
      repeat (5) cyc();
      checks++;
      if (ifc.tick !== 1'b0 || dut.u_core.cnt_o !== 9'd503) begin
         fails++;
         $display("FAIL en_hold: tick=%b cnt=%0d want 0 503",
                  ifc.tick, dut.u_core.cnt_o);
      end
      ifc.en = 1'b1;
      count_to_tick(40, n);
      checks++;
      if (n !== 9 || ifc.div_out !== 1'b1) begin
         fails++;
         $display("FAIL en_delay: n=%0d div=%b want 9 1", n, ifc.div_out);
      end
      repeat (11) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if (ifc.div_out !== 1'b0 || ifc.tick !== 1'b0 || ifc.sym_act !== 1'b0 ||
          dut.u_core.cnt_o !== 9'd0) begin
         fails++;
         $display("FAIL rst_on_wrap: div=%b tick=%b sym=%b cnt=%0d want 0 0 0 0",
                  ifc.div_out, ifc.tick, ifc.sym_act, dut.u_core.cnt_o);
      end
   endtask

   initial begin
      test_reset();
      test_mark_period();
      test_extremes();
      test_switch();
      test_wrap_edges();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
